// File: rtl/jt89_pkg.sv
// Shared constants and helpers for the JT89 multi-channel tone bank.
package jt89_pkg;

  localparam logic WR_PERIOD = 1'b0;
  localparam logic WR_ATTEN  = 1'b1;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] atten2mag(input logic [3:0] atten, input int ow);
    logic [31:0] m;
    case (atten)
      4'd0:    m = 32'd511;
      4'd1:    m = 32'd322;
      4'd2:    m = 32'd203;
      4'd3:    m = 32'd128;
      4'd4:    m = 32'd81;
      4'd5:    m = 32'd51;
      4'd6:    m = 32'd32;
      4'd7:    m = 32'd20;
      4'd8:    m = 32'd13;
      4'd9:    m = 32'd8;
      4'd10:   m = 32'd5;
      4'd11:   m = 32'd3;
      4'd12:   m = 32'd2;
      4'd13:   m = 32'd1;
      4'd14:   m = 32'd1;
      default: m = 32'd0;
    endcase
    return m << (ow - 10);
  endfunction

endpackage

// File: rtl/jt89_tone_ch.sv
// One square-wave tone channel: period/attenuation registers, down-counter and polarity.
module jt89_tone_ch
  import jt89_pkg::*;
#(
  parameter int CW  = 10,
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_ch_i,
  input  logic          wr_sel_i,
  input  logic [CW-1:0] wr_data_i,
  output logic [3:0]    atten_o,
  output logic          v_o
);

  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    atten_q, atten_d;
  logic          v_q, v_d;
  logic          hit;

  assign hit = wr_en_i && (wr_ch_i == IW'(IDX));

  // Reload reads period_q, so a write landing on a reload cycle only affects the next one.
  always_comb begin
    period_d = period_q;
    atten_d  = atten_q;
    cnt_d    = cnt_q;
    v_d      = v_q;
    if (clken_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = period_q;
        v_d   = (period_q >= CW'(2)) ? ~v_q : 1'b1;
      end
    end
    if (hit && wr_sel_i == WR_PERIOD) period_d = wr_data_i;
    if (hit && wr_sel_i == WR_ATTEN)  atten_d  = wr_data_i[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
      atten_q  <= 4'hF;
      v_q      <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      atten_q  <= atten_d;
      v_q      <= v_d;
    end
  end

  assign atten_o = atten_q;
  assign v_o     = v_q;

endmodule

// File: rtl/jt89_tone_bank.sv
// CH tone channels sharing one write port, with a time-multiplexed sample/mix pipeline.
module jt89_tone_bank
  import jt89_pkg::*;
#(
  parameter  int CH = 3,
  parameter  int CW = 10,
  parameter  int OW = 10,
  localparam int MW = OW + $clog2(CH + 1),
  localparam int IW = idx_w(CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_ch,
  input  logic                 wr_sel,
  input  logic [CW-1:0]        wr_data,
  output logic [CH*OW-1:0]     ch_snd,
  output logic signed [MW-1:0] mix,
  output logic                 mix_valid
);

  localparam logic [IW-1:0] LAST = IW'(CH - 1);

  logic [3:0]           atten_w [CH];
  logic                 v_w     [CH];
  logic signed [OW-1:0] snd_q   [CH];

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      jt89_tone_ch #(
        .CW  (CW),
        .IW  (IW),
        .IDX (gi)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .clken_i   (clken),
        .wr_en_i   (wr_en),
        .wr_ch_i   (wr_ch),
        .wr_sel_i  (wr_sel),
        .wr_data_i (wr_data),
        .atten_o   (atten_w[gi]),
        .v_o       (v_w[gi])
      );
      assign ch_snd[gi*OW +: OW] = snd_q[gi];
    end
  endgenerate

  logic [IW-1:0]        scan_q, scan_d, sidx_q;
  logic                 s1_vld_q;
  logic [31:0]          mag_full;
  logic [OW-1:0]        mag;
  logic signed [OW-1:0] term_d, term_q;
  logic signed [MW-1:0] term_ext, acc_q, mix_q;
  logic                 mix_valid_q;

  // Stage 0: pick the scanned channel and form its signed term.
  always_comb begin
    scan_d   = (scan_q == LAST) ? '0 : scan_q + 1'b1;
    mag_full = atten2mag(atten_w[scan_q], OW);
    mag      = mag_full[OW-1:0];
    term_d   = v_w[scan_q] ? mag : ('0 - mag);
  end

  assign term_ext = {{(MW-OW){term_q[OW-1]}}, term_q};

  // Stage 1: publish the term and accumulate; the last channel closes the mix frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q      <= '0;
      sidx_q      <= '0;
      s1_vld_q    <= 1'b0;
      term_q      <= '0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      for (int k = 0; k < CH; k++) snd_q[k] <= '0;
    end else begin
      scan_q      <= scan_d;
      sidx_q      <= scan_q;
      term_q      <= term_d;
      s1_vld_q    <= 1'b1;
      mix_valid_q <= 1'b0;
      if (s1_vld_q) begin
        snd_q[sidx_q] <= term_q;
        if (sidx_q == LAST) begin
          mix_q       <= acc_q + term_ext;
          acc_q       <= '0;
          mix_valid_q <= 1'b1;
        end else begin
          acc_q <= acc_q + term_ext;
        end
      end
    end
  end

  assign mix       = mix_q;
  assign mix_valid = mix_valid_q;

endmodule
